// File: rtl/sprite_motion_ctl_if.sv
// -----------------------------------------------------------------------------
// sprite_motion_ctl_if
//   Bundles the signals between the sprite position controller and its
//   surroundings (timing chain, buttons, draw_rect).
//   vblnk_in   : vertical blank from the timing chain
//   btn_left   : asynchronous button, active-high
//   btn_right  : asynchronous button, active-high
//   btn_jump   : asynchronous button, active-high
//   xpos       : sprite left edge (12 bit), to draw_rect
//   ypos       : sprite top edge (12 bit), to draw_rect
//   airborne   : high while the sprite is rising or falling
//   master : the side driving vblank/buttons and consuming the position
//   slave  : the position controller itself
// -----------------------------------------------------------------------------
interface sprite_motion_ctl_if;
   logic        vblnk_in;
   logic        btn_left;
   logic        btn_right;
   logic        btn_jump;
   logic [11:0] xpos;
   logic [11:0] ypos;
   logic        airborne;

   modport master (
      output vblnk_in, btn_left, btn_right, btn_jump,
      input  xpos, ypos, airborne
   );

   modport slave (
      input  vblnk_in, btn_left, btn_right, btn_jump,
      output xpos, ypos, airborne
   );
endinterface

// File: rtl/sprite_motion_ctl.sv
// -----------------------------------------------------------------------------
// sprite_motion_ctl
//   Per-frame position controller for the player sprite. Walks left/right on
//   buttons, jumps with an integer gravity model and clamps to the screen.
//   Position is updated once per frame on the first clock of vertical blank,
//   so draw_rect never sees the sprite move mid-frame.
// Ports
//   pclk : pixel clock
//   rst  : asynchronous, active-high reset
//   bus  : sprite_motion_ctl_if.slave (vblnk_in, buttons in; xpos, ypos,
//          airborne out)
// -----------------------------------------------------------------------------
module sprite_motion_ctl #(
   parameter int SCREEN_W    = 1024,
   parameter int SCREEN_H    = 768,
   parameter int RECT_WIDTH  = 64,
   parameter int RECT_HEIGHT = 64,
   parameter int X_INIT      = 480,
   parameter int Y_GROUND    = 640,
   parameter int STEP_X      = 4,
   parameter int JUMP_V0     = 12,
   parameter int GRAVITY     = 1
) (
   input  logic               pclk,
   input  logic               rst,
   sprite_motion_ctl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_RISE   = 2'd1,
      ST_FALL   = 2'd2
   } state_t;

   // All position arithmetic is carried in 13 bits so sums never wrap.
   localparam logic [12:0] X_MAX   = 13'(SCREEN_W - 1 - RECT_WIDTH);
   localparam logic [12:0] Y_MAX   = 13'(SCREEN_H - 1 - RECT_HEIGHT);
   // Ground level is kept on screen even if Y_GROUND is set too low.
   localparam logic [12:0] Y_FLOOR = (13'(Y_GROUND) <= Y_MAX) ? 13'(Y_GROUND) : Y_MAX;
   localparam logic [12:0] STEP    = 13'(STEP_X);
   localparam logic [11:0] X_RST   = 12'(X_INIT);
   localparam logic [5:0]  V0      = 6'(JUMP_V0);
   localparam logic [5:0]  GRAV    = 6'(GRAVITY);

   // Button vectors are ordered {jump, right, left}.
   logic [2:0]  btn_s1_q, btn_s1_d;
   logic [2:0]  btn_s2_q, btn_s2_d;
   logic        jump_prev_q, jump_prev_d;
   logic        vblnk_prev_q, vblnk_prev_d;
   logic        jump_req_q, jump_req_d;
   state_t      state_q, state_d;
   logic [5:0]  vel_q, vel_d;
   logic [11:0] x_q, x_d;
   logic [11:0] y_q, y_d;
   logic        airborne_q, airborne_d;

   logic        tick;
   logic        jump_edge;
   logic        go_left;
   logic        go_right;
   logic [12:0] x_wide;
   logic [12:0] y_wide;
   logic [12:0] x_step;
   logic [12:0] y_sum;
   logic [6:0]  vel_fall;

   always_comb begin
      btn_s1_d     = {bus.btn_jump, bus.btn_right, bus.btn_left};
      btn_s2_d     = btn_s1_q;
      jump_prev_d  = btn_s2_q[2];
      vblnk_prev_d = bus.vblnk_in;

      tick      = bus.vblnk_in & ~vblnk_prev_q;
      jump_edge = btn_s2_q[2] & ~jump_prev_q;
      go_left   = btn_s2_q[0] & ~btn_s2_q[1];
      go_right  = btn_s2_q[1] & ~btn_s2_q[0];

      x_wide = {1'b0, x_q};
      y_wide = {1'b0, y_q};

      x_step = x_wide + STEP;
      if (x_step > X_MAX) begin
         x_step = X_MAX;
      end

      // Falling speed saturates at the launch speed.
      vel_fall = {1'b0, vel_q} + {1'b0, GRAV};
      if (vel_fall > {1'b0, V0}) begin
         vel_fall = {1'b0, V0};
      end
      y_sum = y_wide + {6'd0, vel_fall};

      x_d        = x_q;
      y_d        = y_q;
      vel_d      = vel_q;
      state_d    = state_q;
      airborne_d = airborne_q;

      // A jump edge coinciding with the tick survives into the next frame.
      jump_req_d = jump_req_q;
      if (tick) begin
         jump_req_d = 1'b0;
      end
      if (jump_edge) begin
         jump_req_d = 1'b1;
      end

      if (tick) begin
         if (go_left) begin
            x_d = (x_wide < STEP) ? 12'd0 : (x_q - STEP[11:0]);
         end else if (go_right) begin
            x_d = x_step[11:0];
         end

         case (state_q)
            ST_GROUND: begin
               y_d   = Y_FLOOR[11:0];
               vel_d = 6'd0;
               if (jump_req_q) begin
                  state_d = ST_RISE;
                  vel_d   = V0;
               end
            end
            ST_RISE: begin
               if ({7'd0, vel_q} > y_wide) begin
                  // Would leave the top of the screen: stop at row 0.
                  y_d     = 12'd0;
                  vel_d   = 6'd0;
                  state_d = ST_FALL;
               end else begin
                  y_d = y_q - {6'd0, vel_q};
                  if (vel_q <= GRAV) begin
                     vel_d   = 6'd0;
                     state_d = ST_FALL;
                  end else begin
                     vel_d = vel_q - GRAV;
                  end
               end
            end
            ST_FALL: begin
               if (y_sum >= Y_FLOOR) begin
                  y_d     = Y_FLOOR[11:0];
                  vel_d   = 6'd0;
                  state_d = ST_GROUND;
               end else begin
                  y_d   = y_sum[11:0];
                  vel_d = vel_fall[5:0];
               end
            end
            default: begin
               y_d     = Y_FLOOR[11:0];
               vel_d   = 6'd0;
               state_d = ST_GROUND;
            end
         endcase

         airborne_d = (state_d != ST_GROUND);
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         btn_s1_q     <= 3'd0;
         btn_s2_q     <= 3'd0;
         jump_prev_q  <= 1'b0;
         vblnk_prev_q <= 1'b0;
         jump_req_q   <= 1'b0;
         state_q      <= ST_GROUND;
         vel_q        <= 6'd0;
         x_q          <= X_RST;
         y_q          <= Y_FLOOR[11:0];
         airborne_q   <= 1'b0;
      end else begin
         btn_s1_q     <= btn_s1_d;
         btn_s2_q     <= btn_s2_d;
         jump_prev_q  <= jump_prev_d;
         vblnk_prev_q <= vblnk_prev_d;
         jump_req_q   <= jump_req_d;
         state_q      <= state_d;
         vel_q        <= vel_d;
         x_q          <= x_d;
         y_q          <= y_d;
         airborne_q   <= airborne_d;
      end
   end

   assign bus.xpos     = x_q;
   assign bus.ypos     = y_q;
   assign bus.airborne = airborne_q;

endmodule

// File: tb/tb_sprite_motion_ctl.sv
// -----------------------------------------------------------------------------
// tb_sprite_motion_ctl
//   Frame-based stimulus for sprite_motion_ctl. Each frame is FRAME pixel
//   clocks with vblank raised at cycle VB_START. A reference model advances
//   one step per frame and pushes the expected position; a monitor pops it on
//   every vblank rising edge and checks that outputs hold between ticks.
// -----------------------------------------------------------------------------
module tb_sprite_motion_ctl;

   localparam int FRAME    = 24;
   localparam int VB_START = 16;
   localparam int VB_LEN   = 4;
   localparam int X0       = 480;
   localparam int YG       = 640;
   localparam int XMAX     = 959;
   localparam int STEP     = 4;
   localparam int V0       = 12;
   localparam int G        = 1;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic        air;
   } obs_t;

   logic pclk = 1'b0;
   logic rst  = 1'b0;

   sprite_motion_ctl_if bus();

   sprite_motion_ctl dut (
      .pclk (pclk),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 pclk = ~pclk;

   obs_t exp_q[$];
   int   checks = 0;
   int   passes = 0;
   bit   mon_en = 1'b0;

   // Reference model state: position, speed, airborne, going-up, pending jump.
   int mx, my, mv;
   bit m_air, m_up, m_carry;

   function automatic obs_t dut_obs();
      obs_t o;
      o.x   = bus.xpos;
      o.y   = bus.ypos;
      o.air = bus.airborne;
      return o;
   endfunction

   function automatic obs_t reset_obs();
      obs_t o;
      o.x   = 12'(X0);
      o.y   = 12'(YG);
      o.air = 1'b0;
      return o;
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s @%0t: got x=%0d y=%0d air=%0d, expected x=%0d y=%0d air=%0d",
                  name, $time, act.x, act.y, act.air, exp.x, exp.y, exp.air);
      end
   endtask

   task automatic model_reset();
      mx = X0; my = YG; mv = 0;
      m_air = 1'b0; m_up = 1'b0; m_carry = 1'b0;
   endtask

   task automatic model_tick(input bit l, input bit r, input bit req);
      int vn;
      if (l && !r)      mx = (mx < STEP) ? 0 : mx - STEP;
      else if (r && !l) mx = (mx + STEP > XMAX) ? XMAX : mx + STEP;
      if (!m_air) begin
         my = YG;
         if (req) begin
            m_air = 1'b1; m_up = 1'b1; mv = V0;
         end
      end else if (m_up) begin
         if (mv > my) begin
            my = 0; mv = 0; m_up = 1'b0;
         end else begin
            my = my - mv;
            if (mv <= G) begin
               mv = 0; m_up = 1'b0;
            end else begin
               mv = mv - G;
            end
         end
      end else begin
         vn = (mv + G > V0) ? V0 : mv + G;
         if (my + vn >= YG) begin
            my = YG; mv = 0; m_air = 1'b0;
         end else begin
            my = my + vn; mv = vn;
         end
      end
   endtask

   // One frame. The jump pulse starts at cycle jo and lasts 3 clocks; after
   // the 2-flop synchroniser its edge lands on clock jo+3. The tick is on
   // clock VB_START+1, so jo <= VB_START-3 is seen at this tick and later
   // pulses carry over to the next one.
   task automatic frame(input bit l, input bit r, input bit j, input int jo);
      bit   req;
      obs_t e;
      if (j && jo <= VB_START - 3) m_carry = 1'b1;
      req     = m_carry;
      m_carry = 1'b0;
      model_tick(l, r, req);
      if (j && jo > VB_START - 3) m_carry = 1'b1;
      e.x = 12'(mx); e.y = 12'(my); e.air = m_air;
      exp_q.push_back(e);
      for (int c = 0; c < FRAME; c++) begin
         @(posedge pclk);
         #2;
         bus.btn_left  = l;
         bus.btn_right = r;
         bus.vblnk_in  = (c >= VB_START) && (c < VB_START + VB_LEN);
         bus.btn_jump  = j && (c >= jo) && (c < jo + 3);
      end
   endtask

   task automatic idle_frames(input int n);
      for (int i = 0; i < n; i++) frame(1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic apply_reset();
      @(posedge pclk);
      #2;
      bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_jump = 1'b0;
      bus.vblnk_in = 1'b0;
      rst = 1'b1;
      #1;
      check("reset_async", dut_obs(), reset_obs());
      model_reset();
      repeat (3) @(posedge pclk);
      #2;
      rst = 1'b0;
      repeat (4) @(posedge pclk);
   endtask

   // Monitor: pops one expectation per vblank rising edge, checks hold otherwise.
   initial begin
      obs_t last;
      bit   vb_prev;
      bit   is_tick;
      int   tick_no;
      last    = reset_obs();
      vb_prev = 1'b0;
      tick_no = 0;
      forever begin
         @(posedge pclk);
         is_tick = bus.vblnk_in && !vb_prev && !rst;
         vb_prev = rst ? 1'b0 : bus.vblnk_in;
         #1;
         if (mon_en) begin
            if (rst) begin
               last = reset_obs();
               check("reset_hold", dut_obs(), last);
            end else if (is_tick) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  $display("FAIL tick_unexpected @%0t: got a tick, required an expectation in queue", $time);
               end else begin
                  last = exp_q.pop_front();
                  check("tick", dut_obs(), last);
                  $display("tick %0d x=%0d y=%0d air=%0d", tick_no,
                           bus.xpos, bus.ypos, bus.airborne);
                  tick_no++;
               end
            end else begin
               check("hold", dut_obs(), last);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "timeout");
   end

   initial begin
      bus.vblnk_in  = 1'b0;
      bus.btn_left  = 1'b0;
      bus.btn_right = 1'b0;
      bus.btn_jump  = 1'b0;
      model_reset();
      #1;
      apply_reset();
      mon_en = 1'b1;

      // Idle frames, then walk right into the clamp and release.
      idle_frames(3);
      for (int i = 0; i < 130; i++) frame(1'b0, 1'b1, 1'b0, 0);
      idle_frames(3);

      // Walk left from the start position into 0, then both buttons.
      apply_reset();
      for (int i = 0; i < 125; i++) frame(1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 3; i++)   frame(1'b1, 1'b1, 1'b0, 0);

      // Full jump arc.
      frame(1'b0, 1'b0, 1'b1, 4);
      idle_frames(26);

      // Jump pressed again while falling is ignored.
      frame(1'b0, 1'b0, 1'b1, 4);
      idle_frames(15);
      frame(1'b0, 1'b0, 1'b1, 4);
      idle_frames(14);

      // Reset mid-rise at y=590, then jump again.
      frame(1'b0, 1'b0, 1'b1, 4);
      idle_frames(5);
      apply_reset();
      frame(1'b0, 1'b0, 1'b1, 4);
      idle_frames(26);

      // Jump edge exactly on the tick edge.
      frame(1'b0, 1'b0, 1'b1, VB_START - 2);
      idle_frames(27);

      // Randomised walking and jumping.
      for (int i = 0; i < 150; i++) begin
         frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0), int'($urandom_range(2, 20)));
      end
      idle_frames(2);
      repeat (4) @(posedge pclk);

      checks++;
      if (exp_q.size() == 0) begin
         passes++;
      end else begin
         $display("FAIL queue_drain: got %0d pending expectations, required 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
